// File: rtl/pllseq_pkg.sv
// Shared types, default timing constants and counter-width helpers for the PLL enable-clock sequencer.
// Latency: n/a. Backpressure: n/a.
package pllseq_pkg;

    typedef enum logic [2:0] {
        PLL_RST,
        WAIT_LOCK,
        EN_CLK,
        REL_RST,
        RUN
    } state_e;

    localparam int DEF_NUM_CLK             = 4;
    localparam int DEF_PLL_RST_CYCLES      = 16;
    localparam int DEF_LOCK_STABLE_CYCLES  = 64;
    localparam int DEF_LOCK_TIMEOUT_CYCLES = 50000;
    localparam int DEF_ENCLK_GAP_CYCLES    = 4;
    localparam int DEF_RST_HOLD_CYCLES     = 8;

    function automatic int max2(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

    function automatic int cnt_width(input int max_val);
        return (max_val < 1) ? 1 : $clog2(max_val + 1);
    endfunction

endpackage

// File: rtl/pllseq_sync2.sv
// Two-flop synchronizer bringing the raw PLL lock into the reference clock domain.
// Latency: 2 cycles. Backpressure: none.
module pllseq_sync2 (
    input  logic clk,
    input  logic rst,
    input  logic d_i,
    output logic q_o
);

    (* ASYNC_REG = "TRUE" *) logic meta_q;
    (* ASYNC_REG = "TRUE" *) logic sync_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            meta_q <= 1'b0;
            sync_q <= 1'b0;
        end else begin
            meta_q <= d_i;
            sync_q <= meta_q;
        end
    end

    assign q_o = sync_q;

endmodule

// File: rtl/pll_enclk_sequencer.sv
// PLL reset / lock qualification / ordered enclk gating with per-domain reset release; optional PLLSEQ_LOCK_TIMEOUT_EN retry.
// Latency: lock seen 2 cycles after pll_lock; one channel change in flight at a time. Backpressure: none.
module pll_enclk_sequencer
    import pllseq_pkg::*;
#(
    parameter int NUM_CLK             = DEF_NUM_CLK,
    parameter int PLL_RST_CYCLES      = DEF_PLL_RST_CYCLES,
    parameter int LOCK_STABLE_CYCLES  = DEF_LOCK_STABLE_CYCLES,
    parameter int LOCK_TIMEOUT_CYCLES = DEF_LOCK_TIMEOUT_CYCLES,
    parameter int ENCLK_GAP_CYCLES    = DEF_ENCLK_GAP_CYCLES,
    parameter int RST_HOLD_CYCLES     = DEF_RST_HOLD_CYCLES
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               pll_lock,
    input  logic [NUM_CLK-1:0] clk_en_req,
    output logic               pll_reset,
    output logic [NUM_CLK-1:0] enclk,
    output logic [NUM_CLK-1:0] periph_rst,
    output logic               ready,
    output logic               lock_fail
);

    localparam int MAXP = max2(max2(max2(PLL_RST_CYCLES, LOCK_STABLE_CYCLES),
                                    max2(LOCK_TIMEOUT_CYCLES, ENCLK_GAP_CYCLES)), RST_HOLD_CYCLES);
    localparam int CW = cnt_width(MAXP);
    localparam int IW = cnt_width(NUM_CLK);
    localparam int SW = (NUM_CLK > 1) ? $clog2(NUM_CLK) : 1;

    state_e             state_q, state_d;
    logic [CW-1:0]      cnt_q, cnt_d;
    logic [NUM_CLK-1:0] req_q, req_d, enclk_q, enclk_d, prst_q, prst_d;
    logic [IW-1:0]      idx_q, idx_d;
    logic [SW-1:0]      ch_q, ch_d;
    logic               busy_q, busy_d, rise_q, rise_d;
    logic               lock_s;
    logic               hit, more, dhit;
    logic [SW-1:0]      hit_ch, dch;
    logic [NUM_CLK-1:0] diff;
`ifdef PLLSEQ_LOCK_TIMEOUT_EN
    logic [CW-1:0]      tcnt_q, tcnt_d;
    logic               fail_q, fail_d;
`endif

    pllseq_sync2 u_lock_sync (
        .clk (clk),
        .rst (rst),
        .d_i (pll_lock),
        .q_o (lock_s)
    );

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        req_d   = req_q;
        enclk_d = enclk_q;
        prst_d  = prst_q;
        idx_d   = idx_q;
        ch_d    = ch_q;
        busy_d  = busy_q;
        rise_d  = rise_q;
`ifdef PLLSEQ_LOCK_TIMEOUT_EN
        tcnt_d  = tcnt_q;
        fail_d  = fail_q;
`endif
        // Next requested channel at or above idx, and whether another one follows it.
        hit    = 1'b0;
        more   = 1'b0;
        hit_ch = '0;
        for (int i = 0; i < NUM_CLK; i++) begin
            if (req_q[i] && (i >= int'(idx_q))) begin
                if (!hit) begin
                    hit    = 1'b1;
                    hit_ch = SW'(i);
                end else begin
                    more = 1'b1;
                end
            end
        end
        diff = clk_en_req ^ req_q;
        dhit = 1'b0;
        dch  = '0;
        for (int i = 0; i < NUM_CLK; i++) begin
            if (diff[i] && !dhit) begin
                dhit = 1'b1;
                dch  = SW'(i);
            end
        end

        case (state_q)
            PLL_RST: begin
                // A count of 0 only occurs straight out of async reset.
                if (cnt_q == CW'(1)) begin
                    state_d = WAIT_LOCK;
                    cnt_d   = CW'(LOCK_STABLE_CYCLES);
`ifdef PLLSEQ_LOCK_TIMEOUT_EN
                    tcnt_d  = CW'(LOCK_TIMEOUT_CYCLES - 1);
`endif
                end else if (cnt_q == '0) begin
                    cnt_d = CW'(PLL_RST_CYCLES - 1);
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end
            WAIT_LOCK: begin
                if (!lock_s) begin
                    cnt_d = CW'(LOCK_STABLE_CYCLES);
                end else if (cnt_q == '0) begin
                    req_d   = clk_en_req;
                    idx_d   = '0;
                    cnt_d   = '0;
                    state_d = EN_CLK;
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
`ifdef PLLSEQ_LOCK_TIMEOUT_EN
                if (state_d == WAIT_LOCK) begin
                    if (tcnt_q == '0) begin
                        fail_d  = 1'b1;
                        state_d = PLL_RST;
                        cnt_d   = CW'(PLL_RST_CYCLES);
                    end else begin
                        tcnt_d = tcnt_q - CW'(1);
                    end
                end
`endif
            end
            EN_CLK: begin
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - CW'(1);
                end else begin
                    if (hit) begin
                        enclk_d[hit_ch] = 1'b1;
                    end
                    if (hit && more) begin
                        idx_d = IW'(hit_ch) + IW'(1);
                        cnt_d = CW'(ENCLK_GAP_CYCLES - 1);
                    end else begin
                        state_d = REL_RST;
                        cnt_d   = CW'(RST_HOLD_CYCLES - 1);
                    end
                end
            end
            REL_RST: begin
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - CW'(1);
                end else begin
                    prst_d  = ~enclk_q;
                    busy_d  = 1'b0;
                    state_d = RUN;
                end
            end
            RUN: begin
                if (busy_q) begin
                    if (cnt_q != '0) begin
                        cnt_d = cnt_q - CW'(1);
                    end else begin
                        if (rise_q) begin
                            prst_d[ch_q] = 1'b0;
                            req_d[ch_q]  = 1'b1;
                        end else begin
                            enclk_d[ch_q] = 1'b0;
                            req_d[ch_q]   = 1'b0;
                        end
                        busy_d = 1'b0;
                    end
                end else if (dhit) begin
                    busy_d = 1'b1;
                    ch_d   = dch;
                    rise_d = clk_en_req[dch];
                    if (clk_en_req[dch]) begin
                        enclk_d[dch] = 1'b1;
                        cnt_d        = CW'(RST_HOLD_CYCLES - 1);
                    end else begin
                        prst_d[dch] = 1'b1;
                        cnt_d       = CW'(1);
                    end
                end
            end
            default: begin
                state_d = PLL_RST;
                cnt_d   = CW'(PLL_RST_CYCLES);
            end
        endcase

        // Losing lock after acceptance overrides everything decided above.
        if (!lock_s && (state_q == EN_CLK || state_q == REL_RST || state_q == RUN)) begin
            state_d = PLL_RST;
            cnt_d   = CW'(PLL_RST_CYCLES);
            enclk_d = '0;
            prst_d  = '1;
            req_d   = req_q;
            idx_d   = idx_q;
            busy_d  = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= PLL_RST;
            cnt_q   <= '0;
            req_q   <= '0;
            enclk_q <= '0;
            prst_q  <= '1;
            idx_q   <= '0;
            ch_q    <= '0;
            busy_q  <= 1'b0;
            rise_q  <= 1'b0;
`ifdef PLLSEQ_LOCK_TIMEOUT_EN
            tcnt_q  <= '0;
            fail_q  <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            req_q   <= req_d;
            enclk_q <= enclk_d;
            prst_q  <= prst_d;
            idx_q   <= idx_d;
            ch_q    <= ch_d;
            busy_q  <= busy_d;
            rise_q  <= rise_d;
`ifdef PLLSEQ_LOCK_TIMEOUT_EN
            tcnt_q  <= tcnt_d;
            fail_q  <= fail_d;
`endif
        end
    end

    assign pll_reset  = (state_q == PLL_RST);
    assign enclk      = enclk_q;
    assign periph_rst = prst_q;
    assign ready      = (state_q == RUN);
`ifdef PLLSEQ_LOCK_TIMEOUT_EN
    assign lock_fail  = fail_q;
`else
    assign lock_fail  = 1'b0;
`endif

endmodule
